// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory system (slave).
// Request/grant/response handshake with lane-formatted write data and byte enables.
interface load_store_unit_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: validates core accesses, formats stores, runs the data-bus handshake
// with an optional timeout, and returns sign/zero-extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata_in,
    output logic                      stall,
    output logic [31:0]               rdata,
    output logic                      lsu_done,
    output logic                      lsu_fault,
    load_store_unit_if.master         dbus
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

    state_t      state_r, state_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lo_r;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [31:0] cnt_r;
    logic        to_r, to_s;
    logic        legal_s, accept_s, timeout_s, load_done_s;

    function automatic logic access_ok(input logic [2:0] f3, input logic we, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lo[0];
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic we, input logic [1:0] lo);
        logic [3:0] be;
        if (!we) begin
            be = 4'b1111;
        end else begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << lo;
                2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign legal_s     = access_ok(funct3, mem_we, addr[1:0]);
    assign accept_s    = (state_r == S_IDLE) && mem_req && legal_s;
    assign timeout_s   = (TIMEOUT != 32'd0) && ((cnt_r + 32'd1) == TIMEOUT);
    assign load_done_s = (state_r == S_RESP) && dbus.dbus_rvalid && !we_r;

    assign stall     = accept_s || (state_r == S_REQ) || (state_r == S_RESP);
    assign lsu_done  = (state_r == S_DONE);
    assign lsu_fault = ((state_r == S_IDLE) && mem_req && !legal_s) || ((state_r == S_DONE) && to_r);

    assign dbus.dbus_req   = (state_r == S_REQ);
    assign dbus.dbus_we    = we_r;
    assign dbus.dbus_addr  = addr_r;
    assign dbus.dbus_be    = be_r;
    assign dbus.dbus_wdata = wdata_r;

    // Next-state logic; in REQ an expiring timeout wins over a same-cycle grant.
    always_comb begin
        state_s = state_r;
        to_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (timeout_s) begin
                    state_s = S_DONE;
                    to_s    = 1'b1;
                end else if (dbus.dbus_gnt) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_RESP: begin
                if (dbus.dbus_rvalid) begin
                    state_s = S_DONE;
                end else if (timeout_s) begin
                    state_s = S_DONE;
                    to_s    = 1'b1;
                end else begin
                    state_s = S_RESP;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, timeout flag and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            to_r    <= 1'b0;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            to_r    <= to_s;
            if (accept_s) begin
                cnt_r <= 32'd0;
            end else if ((state_r == S_REQ) || (state_r == S_RESP)) begin
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    // Request latch (held stable for the whole bus transaction) and load result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            lo_r     <= 2'b00;
            addr_r   <= 32'd0;
            be_r     <= 4'b0000;
            wdata_r  <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            if (accept_s) begin
                we_r     <= mem_we;
                funct3_r <= funct3;
                lo_r     <= addr[1:0];
                addr_r   <= {addr[31:2], 2'b00};
                be_r     <= store_be(funct3, mem_we, addr[1:0]);
                wdata_r  <= store_data(funct3, wdata_in);
            end
            if (load_done_s) begin
                rdata <= load_fmt(funct3_r, lo_r, dbus.dbus_rdata);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected completions,
// a negedge monitor pops and compares them whenever lsu_done or lsu_fault pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0, wdata_in = 32'd0;
    logic        stall, lsu_done, lsu_fault;
    logic [31:0] rdata;

    logic        t_req = 1'b0;
    logic        stall2, done2, fault2;
    logic [31:0] rdata2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        fault;
        logic        done;
        logic [31:0] rd;
    } exp_t;
    exp_t exp_q[$];

    load_store_unit_if bus ();
    load_store_unit_if bus2 ();

    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata_in(wdata_in), .stall(stall), .rdata(rdata),
        .lsu_done(lsu_done), .lsu_fault(lsu_fault), .dbus(bus.master)
    );

    load_store_unit #(.TIMEOUT(32'd4)) dut_to (
        .clk(clk), .rst(rst), .mem_req(t_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata_in(wdata_in), .stall(stall2), .rdata(rdata2),
        .lsu_done(done2), .lsu_fault(fault2), .dbus(bus2.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every completion or fault pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (lsu_done || lsu_fault)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got done=%b fault=%b expected no response", lsu_done, lsu_fault);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_done", {31'd0, lsu_done}, {31'd0, e.done});
                check("resp_fault", {31'd0, lsu_fault}, {31'd0, e.fault});
                check("resp_rdata", rdata, e.rd);
            end
        end
    end

    // Legal access; called in the window 2ns after a rising edge with the DUT in IDLE.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int gdly, input int rdly, input logic [31:0] brd,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        exp_q.push_back('{fault: 1'b0, done: 1'b1, rd: erd});
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata_in = wd;
        #1;
        check("stall_req", {31'd0, stall}, 32'd1);
        check("bus_idle", {31'd0, bus.dbus_req}, 32'd0);
        @(posedge clk); #2;
        for (int i = 0; i <= gdly; i++) begin
            check("stall_req_wait", {31'd0, stall}, 32'd1);
            check("bus_req", {31'd0, bus.dbus_req}, 32'd1);
            check("bus_we", {31'd0, bus.dbus_we}, {31'd0, we});
            check("bus_addr", bus.dbus_addr, {a[31:2], 2'b00});
            check("bus_be", {28'd0, bus.dbus_be}, {28'd0, ebe});
            if (we) check("bus_wdata", bus.dbus_wdata, ewd);
            if (i == gdly) bus.dbus_gnt = 1'b1;
            @(posedge clk); #2;
        end
        bus.dbus_gnt = 1'b0;
        check("req_drop", {31'd0, bus.dbus_req}, 32'd0);
        for (int i = 0; i < rdly; i++) begin
            check("stall_resp_wait", {31'd0, stall}, 32'd1);
            @(posedge clk); #2;
        end
        check("stall_resp", {31'd0, stall}, 32'd1);
        bus.dbus_rvalid = 1'b1; bus.dbus_rdata = brd;
        @(posedge clk); #2;
        bus.dbus_rvalid = 1'b0; mem_req = 1'b0;
        check("stall_done", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
    endtask

    // Illegal or misaligned access: fault in the request cycle, no bus traffic.
    task automatic bad_access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] erd);
        exp_q.push_back('{fault: 1'b1, done: 1'b0, rd: erd});
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata_in = 32'h5555AAAA;
        #1;
        check("bad_stall", {31'd0, stall}, 32'd0);
        check("bad_bus_req", {31'd0, bus.dbus_req}, 32'd0);
        @(posedge clk); #2;
        mem_req = 1'b0;
        check("bad_bus_req_after", {31'd0, bus.dbus_req}, 32'd0);
        check("bad_stall_after", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
    endtask

    initial begin
        int cyc;
        bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0; bus.dbus_rdata = 32'd0;
        bus2.dbus_gnt = 1'b0; bus2.dbus_rvalid = 1'b0; bus2.dbus_rdata = 32'd0;
        @(posedge clk); @(posedge clk); #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_done", {31'd0, lsu_done}, 32'd0);
        check("rst_fault", {31'd0, lsu_fault}, 32'd0);
        check("rst_req", {31'd0, bus.dbus_req}, 32'd0);
        check("rst_we", {31'd0, bus.dbus_we}, 32'd0);
        check("rst_addr", bus.dbus_addr, 32'd0);
        check("rst_be", {28'd0, bus.dbus_be}, 32'd0);
        check("rst_wdata", bus.dbus_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Loads: width and extension
        access(1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'd0, 32'hDEADBEEF);
        access(1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF0011, 4'b1111, 32'd0, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 32'h80FF0011, 4'b1111, 32'd0, 32'h00000080);
        access(1'b0, 3'b101, 32'h102, 32'd0, 0, 0, 32'h80FF0011, 4'b1111, 32'd0, 32'h000080FF);
        access(1'b0, 3'b001, 32'h102, 32'd0, 0, 0, 32'h80FF0011, 4'b1111, 32'd0, 32'hFFFF80FF);
        access(1'b0, 3'b000, 32'h100, 32'd0, 1, 2, 32'h1234567F, 4'b1111, 32'd0, 32'h0000007F);

        // Stores: rdata must hold the last load result
        access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0000007F);
        access(1'b1, 3'b000, 32'h201, 32'h00000077, 0, 1, 32'hFFFFFFFF, 4'b0010, 32'h77777777, 32'h0000007F);
        access(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 32'hFFFFFFFF, 4'b1111, 32'hCAFEF00D, 32'h0000007F);
        access(1'b1, 3'b001, 32'h200, 32'h0000BEEF, 0, 0, 32'hFFFFFFFF, 4'b0011, 32'hBEEFBEEF, 32'h0000007F);

        // Rejected accesses
        bad_access(1'b0, 3'b010, 32'h101, 32'h0000007F);
        bad_access(1'b0, 3'b011, 32'h100, 32'h0000007F);
        bad_access(1'b0, 3'b001, 32'h103, 32'h0000007F);
        bad_access(1'b1, 3'b100, 32'h100, 32'h0000007F);
        bad_access(1'b0, 3'b111, 32'h100, 32'h0000007F);

        // Stray handshake signals in IDLE are ignored
        bus.dbus_gnt = 1'b1; bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'h11111111;
        @(posedge clk); #2;
        bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0;
        check("stray_req", {31'd0, bus.dbus_req}, 32'd0);
        check("stray_rdata", rdata, 32'h0000007F);

        // Reset during RESP, then a late rvalid
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #2;
        bus.dbus_gnt = 1'b1;
        @(posedge clk); #2;
        bus.dbus_gnt = 1'b0;
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1; mem_req = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, bus.dbus_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'h12345678;
        @(posedge clk); #2;
        bus.dbus_rvalid = 1'b0;
        check("late_rvalid_rdata", rdata, 32'd0);
        check("late_rvalid_done", {31'd0, lsu_done}, 32'd0);
        check("late_rvalid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;

        // Timeout on the TIMEOUT=4 instance: grant given, rvalid never
        t_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #2;
        check("to_req", {31'd0, bus2.dbus_req}, 32'd1);
        bus2.dbus_gnt = 1'b1;
        @(posedge clk); #2;
        bus2.dbus_gnt = 1'b0;
        cyc = 2;
        while (!done2 && cyc < 20) begin
            check("to_stall", {31'd0, stall2}, 32'd1);
            @(posedge clk); #2;
            cyc++;
        end
        check("to_cycle", cyc, 32'd5);
        check("to_fault", {31'd0, fault2}, 32'd1);
        check("to_rdata", rdata2, 32'd0);
        check("to_bus_req", {31'd0, bus2.dbus_req}, 32'd0);
        check("to_stall_done", {31'd0, stall2}, 32'd0);
        t_req = 1'b0;
        @(posedge clk); #2;
        check("to_idle_done", {31'd0, done2}, 32'd0);
        check("to_idle_fault", {31'd0, fault2}, 32'd0);
        check("to_idle_stall", {31'd0, stall2}, 32'd0);

        @(posedge clk); #2;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
